// File: rtl/lcd_pkg.sv
// Shared types, command constants and helpers for the HD44780-style LCD write engine.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPwrup,
        StInit,
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StWait
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNCSET_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;

    localparam int unsigned INIT_LEN = 6;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == 7'b0000001));
    endfunction

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] byte_v;
        case (idx)
            3'd0, 3'd1, 3'd2: byte_v = CMD_FUNCSET_8B2L;
            3'd3:             byte_v = CMD_DISP_ON;
            3'd4:             byte_v = CMD_CLEAR;
            default:          byte_v = CMD_ENTRY_INC;
        endcase
        return byte_v;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every timed state; done flags the last cycle of a state.
module lcd_delay_timer #(
    parameter int unsigned W         = 20,
    parameter int unsigned RESET_VAL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Saturates at 1 so an idle timer keeps reporting done without wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= W'(RESET_VAL);
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count > W'(1)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == W'(1));

endmodule

// File: rtl/lcd_bus_writer.sv
// HD44780 8-bit parallel write engine: power-up init, then one byte per valid/ready handshake
// with setup, enable pulse, hold and command execution delay.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_SETUP   = 4,
    parameter int unsigned T_EN_HIGH = 25,
    parameter int unsigned T_HOLD    = 5,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_CLEAR   = 82000
) (
    input  logic       clk,
    input  logic       rstBt,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       init_done,
    output logic [7:0] LCD,
    output logic       RS,
    output logic       RW,
    output logic       en
);

    localparam int unsigned MAX_T = max_u(max_u(max_u(T_POWERUP, T_INIT1),
                                                max_u(T_SETUP, T_EN_HIGH)),
                                          max_u(max_u(T_HOLD, T_CMD), T_CLEAR));
    localparam int unsigned CNT_W = $clog2(MAX_T + 1);
    localparam logic [2:0]  INIT_END = 3'(INIT_LEN);

    lcd_state_e       r_state;
    logic [2:0]       r_init_idx;
    logic             r_init_done;
    logic             r_in_ready;
    logic [7:0]       r_lcd;
    logic             r_rs;
    logic             r_en;

    lcd_state_e       w_state_d;
    logic [2:0]       w_init_idx_d;
    logic             w_init_done_d;
    logic [7:0]       w_lcd_d;
    logic             w_rs_d;
    logic             w_start_init;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_exec_delay;
    logic             w_done;

    lcd_delay_timer #(
        .W         (CNT_W),
        .RESET_VAL (T_POWERUP)
    ) u_timer (
        .clk        (clk),
        .rst        (rstBt),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // r_init_idx already points past the byte in flight, so 1 means ROM entry 0.
    always_comb begin
        if (!r_init_done && (r_init_idx == 3'd1)) begin
            w_exec_delay = CNT_W'(T_INIT1);
        end else if (is_long_cmd(r_rs, r_lcd)) begin
            w_exec_delay = CNT_W'(T_CLEAR);
        end else begin
            w_exec_delay = CNT_W'(T_CMD);
        end
    end

    // INIT is resolved in the same cycle it is entered, so ROM bytes cost no extra cycle.
    always_comb begin
        w_state_d    = r_state;
        w_init_idx_d = r_init_idx;
        w_lcd_d      = r_lcd;
        w_rs_d       = r_rs;
        w_start_init = 1'b0;
        w_load       = 1'b0;
        w_load_val   = CNT_W'(T_SETUP);

        unique case (r_state)
            StPwrup: begin
                if (w_done) w_start_init = 1'b1;
            end
            StInit: begin
                w_start_init = 1'b1;
            end
            StIdle: begin
                if (in_valid && r_in_ready) begin
                    w_lcd_d    = in_data;
                    w_rs_d     = in_rs;
                    w_state_d  = StSetup;
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_SETUP);
                end
            end
            StSetup: begin
                if (w_done) begin
                    w_state_d  = StPulse;
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_EN_HIGH);
                end
            end
            StPulse: begin
                if (w_done) begin
                    w_state_d  = StHold;
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_HOLD);
                end
            end
            StHold: begin
                if (w_done) begin
                    w_state_d  = StWait;
                    w_load     = 1'b1;
                    w_load_val = w_exec_delay;
                end
            end
            StWait: begin
                if (w_done) begin
                    if (r_init_idx != INIT_END) begin
                        w_start_init = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: begin
                w_state_d = StPwrup;
            end
        endcase

        if (w_start_init) begin
            w_lcd_d      = init_rom(r_init_idx);
            w_rs_d       = 1'b0;
            w_init_idx_d = r_init_idx + 3'd1;
            w_state_d    = StSetup;
            w_load       = 1'b1;
            w_load_val   = CNT_W'(T_SETUP);
        end
    end

    assign w_init_done_d = r_init_done || (w_state_d == StIdle);

    always_ff @(posedge clk or posedge rstBt) begin
        if (rstBt) begin
            r_state     <= StPwrup;
            r_init_idx  <= 3'd0;
            r_init_done <= 1'b0;
            r_in_ready  <= 1'b0;
            r_lcd       <= 8'h00;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_init_idx  <= w_init_idx_d;
            r_init_done <= w_init_done_d;
            r_in_ready  <= (w_state_d == StIdle) && w_init_done_d;
            r_lcd       <= w_lcd_d;
            r_rs        <= w_rs_d;
            r_en        <= (w_state_d == StPulse);
        end
    end

    assign in_ready  = r_in_ready;
    assign init_done = r_init_done;
    assign LCD       = r_lcd;
    assign RS        = r_rs;
    assign RW        = 1'b0;
    assign en        = r_en;

endmodule
